// File: rtl/axis_fifo_buffer.sv
// First-word-fall-through AXI-stream FIFO with TLAST, packet count
// and almost-full status; level, not pointer compare, tells full from empty.
module axis_fifo_buffer #(
  parameter int N                  = 4,
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_THRESH = 6,
  localparam int W                 = N * DATA_WIDTH,
  localparam int CW                = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [W-1:0]  s_tdata,
  input  logic          s_tlast,
  input  logic          s_tvalid,
  output logic          s_tready,
  output logic [W-1:0]  m_tdata,
  output logic          m_tlast,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [CW-1:0] level,
  output logic          almost_full,
  output logic          empty,
  output logic [CW-1:0] pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_THRESH);

  logic [W:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] pkt_q, pkt_d;
  logic          push, pop;
  logic          pkt_in, pkt_out;

  assign s_tready    = (level_q != FULL_LVL);
  assign m_tvalid    = (level_q != '0);
  assign {m_tlast, m_tdata} = mem_q[rd_ptr_q];
  assign level       = level_q;
  assign pkt_count   = pkt_q;
  assign empty       = (level_q == '0);
  assign almost_full = (level_q >= AF_LVL);

  assign push    = s_tvalid && s_tready;
  assign pop     = m_tvalid && m_tready;
  assign pkt_in  = push && s_tlast;
  assign pkt_out = pop && m_tlast;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      pkt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) level_d = level_q + CW'(1);
      if (pop && !push) level_d = level_q - CW'(1);
      if (pkt_in && !pkt_out) pkt_d = pkt_q + CW'(1);
      if (pkt_out && !pkt_in) pkt_d = pkt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
    end
  end

  // Storage is never cleared; only the pointers and level define contents.
  always_ff @(posedge clk) begin
    if (reset && !flush && push)
      mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

endmodule

// File: tb/tb_axis_fifo_buffer.sv
// Randomised and directed bench for axis_fifo_buffer against a
// queue-based reference model compared on every falling edge.
module tb_axis_fifo_buffer;

  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CW    = 4;

  logic          clk = 0;
  logic          reset, flush;
  logic [W-1:0]  s_tdata;
  logic          s_tlast, s_tvalid, s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tlast, m_tvalid, m_tready;
  logic [CW-1:0] level, pkt_count;
  logic          almost_full, empty;

  int ncmp = 0;
  int nfail = 0;

  axis_fifo_buffer #(
    .N(4), .DATA_WIDTH(8), .DEPTH(DEPTH), .ALMOST_FULL_THRESH(6)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .level(level), .almost_full(almost_full),
    .empty(empty), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {last,data} beats.
  logic [W:0] q[$];
  bit armed = 0;

  always @(posedge clk) begin
    bit pu, po;
    if (!reset) begin
      q.delete();
      armed = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      pu = s_tvalid && (q.size() < DEPTH);
      po = m_tready && (q.size() > 0);
      if (po) void'(q.pop_front());
      if (pu) q.push_back({s_tlast, s_tdata});
    end
  end

  bit         stalled = 0;
  logic [W:0] held;

  always @(negedge clk) begin
    int pk;
    if (armed) begin
      pk = 0;
      foreach (q[i]) pk += int'(q[i][W]);
      chk("m_tvalid", 64'(m_tvalid), 64'(q.size() != 0));
      chk("s_tready", 64'(s_tready), 64'(q.size() != DEPTH));
      chk("level", 64'(level), 64'(q.size()));
      chk("empty", 64'(empty), 64'(q.size() == 0));
      chk("almost_full", 64'(almost_full), 64'(q.size() >= 6));
      chk("pkt_count", 64'(pkt_count), 64'(pk));
      if (q.size() != 0)
        chk("m_beat", 64'({m_tlast, m_tdata}), 64'(q[0]));
      if (stalled && m_tvalid)
        chk("stall_stable", 64'({m_tlast, m_tdata}), 64'(held));
      stalled = m_tvalid && !m_tready && reset && !flush;
      held = {m_tlast, m_tdata};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(int n, int base);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1;
      s_tdata = W'(base + i);
      s_tlast = 0;
      cyc();
    end
    s_tvalid = 0;
  endtask

  initial begin
    int pushed, cycles;
    reset = 0; flush = 0;
    s_tvalid = 1; s_tdata = 32'h5555_AAAA; s_tlast = 1;
    m_tready = 0;
    repeat (2) cyc();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    s_tvalid = 0;
    reset = 1;
    cyc();
    chk("no_store_in_rst", 64'(level), 64'd0);

    s_tvalid = 1; s_tdata = 32'hA1B2C3D4; s_tlast = 1;
    cyc();
    s_tvalid = 0; s_tlast = 0;
    chk("lat_valid", 64'(m_tvalid), 64'd1);
    chk("lat_data", 64'(m_tdata), 64'hA1B2C3D4);
    chk("lat_last", 64'(m_tlast), 64'd1);
    chk("lat_level", 64'(level), 64'd1);
    chk("lat_pkt", 64'(pkt_count), 64'd1);
    m_tready = 1;
    cyc();
    m_tready = 0;
    chk("pop_empty", 64'(empty), 64'd1);
    chk("pop_pkt", 64'(pkt_count), 64'd0);

    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1; s_tdata = W'(i); s_tlast = 0;
      cyc();
      if (i == 4) chk("af_at5", 64'(almost_full), 64'd0);
      if (i == 5) chk("af_at6", 64'(almost_full), 64'd1);
      if (i == 6) chk("rdy_at7", 64'(s_tready), 64'd1);
    end
    chk("full_rdy", 64'(s_tready), 64'd0);
    s_tdata = 32'hFF;
    cyc();
    s_tvalid = 0;
    chk("full_level", 64'(level), 64'd8);
    m_tready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 64'(m_tdata), 64'(i));
      cyc();
    end
    m_tready = 0;
    chk("drain_level", 64'(level), 64'd0);

    s_tvalid = 1; m_tready = 1;
    for (int i = 0; i < 20; i++) begin
      s_tdata = W'(100 + i);
      cyc();
      chk("stream_level", 64'(level), 64'd1);
      chk("stream_data", 64'(m_tdata), 64'(100 + i));
    end
    s_tvalid = 0;
    cyc();
    m_tready = 0;

    pushed = 0;
    cycles = 0;
    while (pushed < 1000 && cycles < 20000) begin
      s_tvalid = 1'($urandom % 2);
      s_tdata = $urandom;
      s_tlast = (pushed % 5) == 4;
      m_tready = 1'($urandom % 2);
      if (s_tvalid && s_tready) pushed++;
      cyc();
      cycles++;
    end
    chk("rand_budget", 64'(pushed >= 1000), 64'd1);
    s_tvalid = 0; s_tlast = 0; m_tready = 1;
    repeat (DEPTH + 1) cyc();
    m_tready = 0;
    chk("rand_drained", 64'(level), 64'd0);
    chk("rand_pkt", 64'(pkt_count), 64'd0);

    push_n(5, 32'h300);
    chk("pre_flush", 64'(level), 64'd5);
    flush = 1; s_tvalid = 1; s_tdata = 32'hDEAD;
    cyc();
    flush = 0; s_tvalid = 0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(m_tvalid), 64'd0);
    chk("flush_rdy", 64'(s_tready), 64'd1);
    cyc();
    chk("flush_lost", 64'(level), 64'd0);

    push_n(5, 32'h400);
    chk("pre_rst", 64'(level), 64'd5);
    reset = 0; s_tvalid = 1; s_tdata = 32'hBEEF;
    cyc();
    reset = 1; s_tvalid = 0;
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_valid", 64'(m_tvalid), 64'd0);

    push_n(3, 32'h500);
    reset = 0; flush = 1; s_tvalid = 1;
    cyc();
    reset = 1; flush = 0; s_tvalid = 0;
    chk("both_level", 64'(level), 64'd0);
    chk("both_pkt", 64'(pkt_count), 64'd0);
    push_n(2, 32'h600);
    m_tready = 1;
    chk("post_both", 64'(m_tdata), 64'h600);
    repeat (3) cyc();
    m_tready = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
